// File: rtl/sdhci_dat_pkg.sv
// sdhci_dat_pkg: shared state and error encodings for the DAT read path
package sdhci_dat_pkg;
  typedef enum logic [2:0] {IDLE, GAP, ISSUE, WAIT_START, RECV} rd_state_e;
  typedef enum logic [1:0] {ERR_NONE, ERR_CRC, ERR_END_BIT, ERR_TIMEOUT} err_code_e;
endpackage

// File: rtl/dat_timeout_cnt.sv
// dat_timeout_cnt: saturating start-bit timeout counter with programmable limit
module dat_timeout_cnt #(
  parameter int Width = 24
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             en_i,
  input  logic [Width-1:0] limit_i,
  output logic             expired_o
);
  logic [Width-1:0] cnt_q, cnt_d;
  // count enabled cycles since the last clear, holding at all-ones
  always_comb cnt_d = clear_i ? '0 : (en_i && ~&cnt_q) ? cnt_q + Width'(1) : cnt_q;
  // counter register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  // expiry is judged on the cycle that would reach the limit; widened so a saturated count never wraps into a match
  assign expired_o = en_i && |limit_i && ({1'b0, cnt_q} + (Width+1)'(1)) == {1'b0, limit_i};
endmodule

// File: rtl/dat_read_seq.sv
// dat_read_seq: multi-block SD DAT read sequencer between buffer and datapath
module dat_read_seq
  import sdhci_dat_pkg::*;
#(
  parameter int MaxBlockBitSize = 10,
  parameter int BlockCountWidth = 16,
  parameter int TimeoutWidth    = 24
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       sd_clk_en_i,
  input  logic                       dat0_i,
  input  logic                       start_i,
  input  logic                       abort_i,
  input  logic [MaxBlockBitSize-1:0] block_size_i,
  input  logic [BlockCountWidth-1:0] block_count_i,
  input  logic [TimeoutWidth-1:0]    timeout_i,
  input  logic                       buf_block_space_i,
  output logic                       rd_start_o,
  output logic                       rd_rst_o,
  input  logic                       rd_data_valid_i,
  input  logic [31:0]                rd_data_i,
  input  logic                       rd_done_i,
  input  logic                       rd_crc_err_i,
  input  logic                       rd_end_bit_err_i,
  output logic                       data_valid_o,
  output logic [31:0]                data_o,
  output logic                       sd_clk_stop_o,
  output logic                       busy_o,
  output logic                       block_done_o,
  output logic                       xfer_done_o,
  output logic                       aborted_o,
  output logic                       err_o,
  output logic [1:0]                 err_code_o,
  output logic [BlockCountWidth-1:0] blocks_done_o
);
  rd_state_e state_q, state_d;
  logic abort_pend_q, abort_pend_d;
  logic [BlockCountWidth-1:0] blocks_q, blocks_d, blocks_inc;
  logic tmo_expired;
  err_code_e err_code;
  logic unused_block_size;
  assign unused_block_size = ^block_size_i;
  dat_timeout_cnt #(.Width(TimeoutWidth)) u_tmo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clear_i   (state_q == ISSUE),
    .en_i      (state_q == WAIT_START && sd_clk_en_i && dat0_i),
    .limit_i   (timeout_i),
    .expired_o (tmo_expired)
  );
  assign blocks_inc    = blocks_q + BlockCountWidth'(1);
  assign busy_o        = state_q != IDLE;
  assign data_valid_o  = state_q == RECV && rd_data_valid_i;
  assign data_o        = data_valid_o ? rd_data_i : '0;
  assign blocks_done_o = blocks_q;
  assign err_code_o    = err_code;
  // state, pending-abort and block-count registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      abort_pend_q <= 1'b0;
      blocks_q     <= '0;
    end else begin
      state_q      <= state_d;
      abort_pend_q <= abort_pend_d;
      blocks_q     <= blocks_d;
    end
  end
  // next-state and single-cycle pulse outputs
  always_comb begin
    state_d       = state_q;
    abort_pend_d  = abort_pend_q;
    blocks_d      = blocks_q;
    rd_start_o    = 1'b0;
    rd_rst_o      = 1'b0;
    sd_clk_stop_o = 1'b0;
    block_done_o  = 1'b0;
    xfer_done_o   = 1'b0;
    aborted_o     = 1'b0;
    err_o         = 1'b0;
    err_code      = ERR_NONE;
    case (state_q)
      IDLE: if (start_i) begin
        state_d      = GAP;
        blocks_d     = '0;
        abort_pend_d = 1'b0;
      end
      GAP: if (abort_pend_q || abort_i) begin
        state_d     = IDLE;
        xfer_done_o = 1'b1;
        aborted_o   = 1'b1;
      end else if (buf_block_space_i) state_d = ISSUE;
      else sd_clk_stop_o = 1'b1;
      ISSUE: begin
        rd_start_o = 1'b1;
        if (sd_clk_en_i) state_d = WAIT_START;
      end
      WAIT_START: if (abort_i) begin
        state_d     = IDLE;
        rd_rst_o    = 1'b1;
        xfer_done_o = 1'b1;
        aborted_o   = 1'b1;
      end else if (sd_clk_en_i && !dat0_i) state_d = RECV;
      else if (tmo_expired) begin
        state_d  = IDLE;
        rd_rst_o = 1'b1;
        err_o    = 1'b1;
        err_code = ERR_TIMEOUT;
      end
      RECV: begin
        if (abort_i) abort_pend_d = 1'b1;
        if (rd_done_i) begin
          if (rd_crc_err_i || rd_end_bit_err_i) begin
            state_d  = IDLE;
            err_o    = 1'b1;
            err_code = rd_crc_err_i ? ERR_CRC : ERR_END_BIT;
          end else begin
            block_done_o = 1'b1;
            blocks_d     = blocks_inc;
            if (abort_pend_q || abort_i) begin
              state_d     = IDLE;
              xfer_done_o = 1'b1;
              aborted_o   = 1'b1;
            end else if (|block_count_i && blocks_inc == block_count_i) begin
              state_d     = IDLE;
              xfer_done_o = 1'b1;
            end else state_d = GAP;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end
endmodule
